// File: rtl/usb_slave_pkg.sv
// Shared definitions for the USB slave: receiver status codes, data PIDs and
// the packet-receive state encoding.
package usb_slave_pkg;

  localparam logic [1:0] RXST_PID  = 2'b00;
  localparam logic [1:0] RXST_DATA = 2'b01;
  localparam logic [1:0] RXST_EOP  = 2'b10;

  localparam logic [3:0] DATA0_PID = 4'h3;
  localparam logic [3:0] DATA1_PID = 4'hB;
  localparam logic [3:0] DATA2_PID = 4'h7;
  localparam logic [3:0] MDATA_PID = 4'hF;

  typedef enum logic [1:0] {
    GP_IDLE,
    GP_WAIT_PID,
    GP_WAIT_DATA,
    GP_DONE
  } getPacketState_t;

  function automatic logic isDataPid(input logic [3:0] pid);
    return (pid == DATA0_PID) || (pid == DATA1_PID) ||
           (pid == DATA2_PID) || (pid == MDATA_PID);
  endfunction

endpackage

// File: rtl/usb_slave_get_packet.sv
// Receive-data engine: waits for a data PID, strips the trailing CRC16 bytes
// and streams the payload into the endpoint RX FIFO, then reports status flags.
module usb_slave_get_packet
  import usb_slave_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 400,
  parameter int MAX_PAYLOAD    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       getPacketEn,
  input  logic [7:0] RxByte,
  input  logic       RxDataWEn,
  input  logic [7:0] RxStatus,
  input  logic       RxFifoFull,
  output logic [7:0] RxFifoData,
  output logic       RxFifoWEn,
  output logic [3:0] RxPID,
  output logic       getPacketRdy,
  output logic       CRCError,
  output logic       bitStuffError,
  output logic       RxOverflow,
  output logic       RxTimeOut
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);

  getPacketState_t state, stateNext;
  logic [TW-1:0] timer, timerNext;
  logic [1:0]    holdCnt, holdCntNext;
  logic [7:0]    hold0, hold0Next;
  logic [7:0]    hold1, hold1Next;
  logic [CW-1:0] payloadCnt, payloadCntNext;
  logic [7:0]    fifoDataNext;
  logic          fifoWEnNext;
  logic [3:0]    pidNext;
  logic          crcErrNext, bitStuffErrNext, overflowNext, timeOutNext;

  logic [1:0] rxType;
  assign rxType = RxStatus[1:0];

  logic unusedStatus;
  assign unusedStatus = ^RxStatus[7:4];

  // Ready is masked by the arm pulse so the controller never sees a stale ready.
  assign getPacketRdy = (state == GP_IDLE) & ~getPacketEn;

  always_comb begin
    stateNext       = state;
    timerNext       = timer;
    holdCntNext     = holdCnt;
    hold0Next       = hold0;
    hold1Next       = hold1;
    payloadCntNext  = payloadCnt;
    fifoDataNext    = RxFifoData;
    fifoWEnNext     = 1'b0;
    pidNext         = RxPID;
    crcErrNext      = CRCError;
    bitStuffErrNext = bitStuffError;
    overflowNext    = RxOverflow;
    timeOutNext     = RxTimeOut;

    case (state)
      GP_IDLE: begin
        if (getPacketEn) begin
          stateNext       = GP_WAIT_PID;
          timerNext       = '0;
          holdCntNext     = 2'd0;
          payloadCntNext  = '0;
          crcErrNext      = 1'b0;
          bitStuffErrNext = 1'b0;
          overflowNext    = 1'b0;
          timeOutNext     = 1'b0;
        end
      end

      GP_WAIT_PID: begin
        if (RxDataWEn && rxType == RXST_PID && isDataPid(RxByte[3:0])) begin
          pidNext   = RxByte[3:0];
          stateNext = GP_WAIT_DATA;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeOutNext = 1'b1;
          stateNext   = GP_DONE;
        end else begin
          timerNext = timer + 1'b1;
        end
      end

      GP_WAIT_DATA: begin
        if (RxDataWEn) begin
          case (rxType)
            RXST_DATA: begin
              // The two newest bytes are withheld: they may turn out to be the CRC.
              hold1Next = hold0;
              hold0Next = RxByte;
              if (holdCnt < 2'd2) begin
                holdCntNext = holdCnt + 1'b1;
              end else if (RxFifoFull || payloadCnt == CW'(MAX_PAYLOAD)) begin
                overflowNext = 1'b1;
              end else begin
                fifoWEnNext    = 1'b1;
                fifoDataNext   = hold1;
                payloadCntNext = payloadCnt + 1'b1;
              end
            end
            RXST_EOP: begin
              crcErrNext      = RxStatus[2] | (holdCnt < 2'd2);
              bitStuffErrNext = RxStatus[3];
              stateNext       = GP_DONE;
            end
            RXST_PID: begin
              crcErrNext = 1'b1;
              stateNext  = GP_DONE;
            end
            default: ;
          endcase
        end
      end

      GP_DONE: stateNext = GP_IDLE;

      default: stateNext = GP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= GP_IDLE;
      timer         <= '0;
      holdCnt       <= 2'd0;
      hold0         <= 8'h00;
      hold1         <= 8'h00;
      payloadCnt    <= '0;
      RxFifoData    <= 8'h00;
      RxFifoWEn     <= 1'b0;
      RxPID         <= 4'h0;
      CRCError      <= 1'b0;
      bitStuffError <= 1'b0;
      RxOverflow    <= 1'b0;
      RxTimeOut     <= 1'b0;
    end else begin
      state         <= stateNext;
      timer         <= timerNext;
      holdCnt       <= holdCntNext;
      hold0         <= hold0Next;
      hold1         <= hold1Next;
      payloadCnt    <= payloadCntNext;
      RxFifoData    <= fifoDataNext;
      RxFifoWEn     <= fifoWEnNext;
      RxPID         <= pidNext;
      CRCError      <= crcErrNext;
      bitStuffError <= bitStuffErrNext;
      RxOverflow    <= overflowNext;
      RxTimeOut     <= timeOutNext;
    end
  end

endmodule

// File: doc/usb_slave_get_packet.md
# usb_slave_get_packet

Receive-data engine for USB slave OUT/SETUP transactions. It sits beside the slave transaction controller and is armed by that controller's `getPacketREn` pulse. It consumes the receiver's byte stream, strips the 16-bit data CRC, and writes the payload into the endpoint RX FIFO. It then reports completion and error flags back on `getPacketRdy`, `CRCError`, `bitStuffError`, `RxOverflow` and `RxTimeOut`.

## Interface
- `TIMEOUT_CYCLES`, default 400: clk cycles allowed between arming and data PID arrival.
- `MAX_PAYLOAD`, default 64: maximum payload bytes accepted per packet.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `getPacketEn` in 1: arm pulse from the transaction controller.
- `RxByte` in 8: receiver byte.
- `RxDataWEn` in 1: `RxByte`/`RxStatus` valid strobe.
- `RxStatus` in 8: `[1:0]` is the byte type (00 PID, 01 data, 10 EOP). `[2]` is the CRC16 error flag and `[3]` is the bit-stuff error flag; both are valid only on EOP. `[7:4]` are ignored.
- `RxFifoFull` in 1: endpoint RX FIFO full.
- `RxFifoData` out 8: payload byte to FIFO.
- `RxFifoWEn` out 1: one-cycle FIFO write strobe.
- `RxPID` out 4: PID nibble of the last accepted data packet.
- `getPacketRdy` out 1: idle/complete.
- `CRCError`, `bitStuffError`, `RxOverflow`, `RxTimeOut` out 1 each: result flags.

## Operation
- States: IDLE, WAIT_PID, WAIT_DATA, DONE.
- IDLE:
  - `getPacketEn`=1 → WAIT_PID.
  - On that transition, clear all four flags, the timer, the hold count and the payload count.
- WAIT_PID:
  - The timer increments every cycle.
  - A strobe with type 00 and `RxByte[1:0]`==2'b11 (DATA0/1/2/MDATA) → latch `RxPID`=`RxByte[3:0]`, go to WAIT_DATA, freeze the timer.
  - Any other strobe is ignored; the timer keeps running.
  - Timer reaches `TIMEOUT_CYCLES`-1 → `RxTimeOut`=1, go to DONE.
- WAIT_DATA uses a 2-byte hold pipeline (h0 newest, h1 oldest) plus a hold count of 0..2.
  - Data strobe with hold count <2: push the byte, count+1.
  - Data strobe with hold count ==2: emit h1 to the FIFO, then shift.
    - Emit means `RxFifoWEn`=1 and payload count +1.
    - If `RxFifoFull` or payload count ==`MAX_PAYLOAD`, do not write and set `RxOverflow`=1 (sticky). The shift still happens.
  - EOP strobe: discard h0/h1 (they are the CRC16).
    - `CRCError` = `RxStatus[2]` | (hold count<2).
    - `bitStuffError` = `RxStatus[3]`.
    - Go to DONE.
  - A PID-type strobe in WAIT_DATA → `CRCError`=1, go to DONE.
  - WAIT_DATA has no timeout; the receiver always terminates a packet with EOP.
- DONE → IDLE unconditionally (one cycle).
- `getPacketRdy` = (state==IDLE) & ~`getPacketEn`. This is masked combinationally so the controller never sees a stale ready in the cycle it asserts the arm pulse.
- `getPacketEn` outside IDLE is ignored.
- Flags and `RxPID` hold their values until the next arm.
- Zero-length packet (PID, 2 CRC bytes, EOP): no FIFO writes, no errors.

## Timing
- Reset values:
  - state IDLE, so `getPacketRdy`=1 whenever `getPacketEn`=0.
  - `RxFifoWEn`=0, `RxFifoData`=8'h00, `RxPID`=4'h0.
  - All four flags 0; timer and both counts 0.
- A reset mid-packet returns the block to IDLE next edge and drops partial data; no FIFO write occurs in the reset cycle.
- Armed at edge N: WAIT_PID from N+1.
  - The first timeout can assert `RxTimeOut` at edge N+`TIMEOUT_CYCLES`.
  - `getPacketRdy` rises one cycle after entering DONE.
- Payload byte k is written on the strobe of byte k+2 (2-strobe latency). `RxFifoWEn` is registered and high for exactly one cycle per write.
- Flags are valid no later than the cycle `getPacketRdy` rises.
- Same-cycle `RxFifoFull` and emit: overflow wins, no write.

## Structure
- Shared package `usb_slave_pkg`:
  - RxStatus type codes (`RXST_PID`=2'b00, `RXST_DATA`=2'b01, `RXST_EOP`=2'b10).
  - PID constants (DATA0=4'h3, DATA1=4'hB, DATA2=4'h7, MDATA=4'hF).
  - State enum.
- The hold pipeline is small; it stays inline. No sub-module.

## Test plan
- Arm, then PID 8'hC3, data 11 22 33, CRC AA BB, EOP with status 8'h02 → FIFO gets 11,22,33 in order; `RxPID`=3; all flags 0; `getPacketRdy` returns high.
- Arm, PID 8'h4B, CRC bytes only, EOP → zero FIFO writes; `RxPID`=B; no flags.
- Arm with no receiver activity → `RxTimeOut`=1 exactly `TIMEOUT_CYCLES` cycles after arm; no writes.
- 70-byte payload plus CRC, `RxFifoFull`=0 → 64 writes, `RxOverflow`=1. Repeat with `RxFifoFull`=1 after the 2nd write → 2 writes, `RxOverflow`=1.
- EOP with status 8'h06, then 8'h0A; and EOP after only 1 data byte → `CRCError`=1; `bitStuffError`=1 with `CRCError`=0; `CRCError`=1.
- Assert `rst` mid-payload → next cycle `getPacketRdy`=1, no further writes. A rearmed packet then completes normally.
